pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives the freeze and flush controls of the PC, the IF/ID register and the ID/EX register, which also inserts bubbles.
- Arbitrates three event sources, highest priority first: memory wait-states, taken branches resolved in EX, and RAW data hazards detected in ID.
- Holds a small FSM for multi-cycle memory accesses and a saturating stall-cycle counter for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 51 +++++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
//   Parameter CNT_W : width of the stall-cycle counter.
//   master : pipeline side; drives the stage status, receives the controls.
//   slave  : controller side; receives the stage status, drives the controls.
// Status (master -> slave):
//   id_valid, src1, src2, two_src           ID-stage operand use
//   exe_wb_en, exe_dest, exe_mem_read       EX-stage producer
//   mem_wb_en, mem_dest                     MEM-stage producer
//   branch_taken                            EX-stage taken branch
//   mem_req, mem_ready                      MEM-stage memory handshake
// Controls (slave -> master):
//   freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, stall_cnt
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [3:0]       src1;
  logic [3:0]       src2;
  logic             two_src;
  logic             exe_wb_en;
  logic [3:0]       exe_dest;
  logic             exe_mem_read;
  logic             mem_wb_en;
  logic [3:0]       mem_dest;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             freeze_pc;
  logic             freeze_if_id;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             freeze_all;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, src1, src2, two_src,
    output exe_wb_en, exe_dest, exe_mem_read,
    output mem_wb_en, mem_dest,
    output branch_taken, mem_req, mem_ready,
    input  freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, stall_cnt
  );

  modport slave (
    input  id_valid, src1, src2, two_src,
    input  exe_wb_en, exe_dest, exe_mem_read,
    input  mem_wb_en, mem_dest,
    input  branch_taken, mem_req, mem_ready,
    output freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all, stall_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
// Priority of events: memory wait-state > taken branch in EX > RAW hazard in ID.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset (0 = reset)
//   bus  : pipeline_hazard_ctrl_if slave modport (stage status in, controls out)
// Parameter CNT_W : width of the saturating stall-cycle counter.
// Optional build macro FORWARDING_EN: when defined, an EX/MEM forwarding unit is
// assumed to exist and only load-use hazards against the EX stage stall.
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [0:0] {
    StRun     = 1'b0,
    StMemWait = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_stall;
  logic m_src1, m_src2;
  logic hazard;

  logic freeze_pc, freeze_if_id, flush_if_id, flush_id_ex, freeze_all;

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
`ifdef FORWARDING_EN
  // Forwarding covers every ALU result; only a load in EX cannot be forwarded in time.
  assign m_src1 = bus.id_valid & bus.exe_wb_en & bus.exe_mem_read &
                  (bus.exe_dest == bus.src1);
  assign m_src2 = bus.id_valid & bus.exe_wb_en & bus.exe_mem_read &
                  (bus.exe_dest == bus.src2);
`else
  // No forwarding: any pending write in EX or MEM blocks the reader in ID.
  assign m_src1 = bus.id_valid &
                  ((bus.exe_wb_en & (bus.exe_dest == bus.src1)) |
                   (bus.mem_wb_en & (bus.mem_dest == bus.src1)));
  assign m_src2 = bus.id_valid &
                  ((bus.exe_wb_en & (bus.exe_dest == bus.src2)) |
                   (bus.mem_wb_en & (bus.mem_dest == bus.src2)));
`endif

  assign hazard = m_src1 | (bus.two_src & m_src2);

  // ---------------------------------------------------------------------------
  // Memory-wait FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:     if (bus.mem_req && !bus.mem_ready) state_d = StMemWait;
      StMemWait: if (bus.mem_ready)                 state_d = StRun;
      default:                                      state_d = StRun;
    endcase
  end

  // Once in MEM_WAIT the access is outstanding regardless of mem_req.
  assign mem_stall = ((state_q == StRun) & bus.mem_req & ~bus.mem_ready) |
                     ((state_q == StMemWait) & ~bus.mem_ready);

  // ---------------------------------------------------------------------------
  // Control outputs (same-cycle, combinational)
  // ---------------------------------------------------------------------------
  always_comb begin
    freeze_pc    = 1'b0;
    freeze_if_id = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    freeze_all   = 1'b0;
    if (!rst) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (mem_stall) begin
      // The whole pipe holds, including a taken branch sitting in EX; it is
      // acted on in the first cycle after the wait ends.
      freeze_all   = 1'b1;
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
    end else if (bus.branch_taken) begin
      // The ID instruction is squashed, so any hazard it has is irrelevant.
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
    end else if (hazard) begin
      freeze_pc    = 1'b1;
      freeze_if_id = 1'b1;
      flush_id_ex  = 1'b1;
    end
  end

  assign bus.freeze_pc    = freeze_pc;
  assign bus.freeze_if_id = freeze_if_id;
  assign bus.flush_if_id  = flush_if_id;
  assign bus.flush_id_ex  = flush_id_ex;
  assign bus.freeze_all   = freeze_all;
  assign bus.stall_cnt    = cnt_q;

  // ---------------------------------------------------------------------------
  // Saturating stall-cycle counter
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (freeze_pc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
